// File: rtl/arith_unit_seq_if.sv
// arith_unit_seq_if: valid/ready operation and result ports of the sequential arithmetic unit
interface arith_unit_seq_if #(parameter int WIDTH = 32);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         op;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out;
    logic               zero;
    logic               ovf;
    logic               dbz;
    modport master (output in_valid, a, b, op, out_ready,
                    input  in_ready, out_valid, out, zero, ovf, dbz);
    modport slave  (input  in_valid, a, b, op, out_ready,
                    output in_ready, out_valid, out, zero, ovf, dbz);
endinterface

// File: rtl/arith_unit_seq.sv
// arith_unit_seq: handshaked ALU; single-cycle add/sub/logic, iterative shift-add multiply and restoring divide
module arith_unit_seq #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    arith_unit_seq_if.slave io
);
    localparam int W2 = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] rb;
    logic             isdiv;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] dif;
    logic [W2-1:0]    res;
    logic             rovf;
    logic [WIDTH:0]   mhi;
    logic [WIDTH:0]   dt;
    logic [W2-1:0]    mnext;
    logic [W2-1:0]    dnext;
    logic             last;
    always_comb begin
        sum   = {1'b0, io.a} + {1'b0, io.b};
        dif   = io.a - io.b;
        res   = io.op == 3'd0 ? W2'(sum) :
                io.op == 3'd1 ? {{WIDTH{dif[WIDTH-1]}}, dif} :
                io.op == 3'd4 ? W2'(io.a & io.b) :
                io.op == 3'd5 ? W2'(io.a | io.b) :
                io.op == 3'd6 ? W2'(io.a ^ io.b) :
                io.op == 3'd7 ? W2'($signed(io.a) < $signed(io.b)) : '0;
        rovf  = io.op == 3'd0 ? (io.a[WIDTH-1] == io.b[WIDTH-1]) && (sum[WIDTH-1] != io.a[WIDTH-1]) :
                io.op == 3'd1 ? (io.a[WIDTH-1] != io.b[WIDTH-1]) && (dif[WIDTH-1] != io.a[WIDTH-1]) : 1'b0;
        // acc = {product high, multiplier}; the carry out of the add shifts back into the top bit
        mhi   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, rb & {WIDTH{acc[0]}}};
        mnext = {mhi, acc[WIDTH-1:1]};
        // acc = {rem, quo}; trial-subtract against the left-shifted remainder, kept one bit wider
        dt    = acc[W2-1:WIDTH-1] - {1'b0, rb};
        dnext = dt[WIDTH] ? {acc[W2-2:0], 1'b0} : {dt[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        last  = cnt == CNT_W'(WIDTH - 1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            rb           <= '0;
            isdiv        <= 1'b0;
            io.out       <= '0;
            io.zero      <= 1'b0;
            io.ovf       <= 1'b0;
            io.dbz       <= 1'b0;
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    rb          <= io.b;
                    isdiv       <= io.op == 3'd3;
                    cnt         <= '0;
                    acc         <= {{WIDTH{1'b0}}, io.a};
                    io.in_ready <= 1'b0;
                    if (io.op == 3'd2) state <= MUL;
                    else if (io.op == 3'd3) state <= DIV;
                    else begin
                        io.out       <= res;
                        io.zero      <= res[WIDTH-1:0] == '0;
                        io.ovf       <= rovf;
                        io.dbz       <= 1'b0;
                        io.out_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                MUL: begin
                    acc <= mnext;
                    cnt <= cnt + 1'b1;
                    if (last) state <= FIN;
                end
                DIV: if (rb == '0) begin
                    acc   <= {acc[WIDTH-1:0], {WIDTH{1'b1}}};
                    state <= FIN;
                end else begin
                    acc <= dnext;
                    cnt <= cnt + 1'b1;
                    if (last) state <= FIN;
                end
                FIN: begin
                    io.out       <= acc;
                    io.zero      <= acc[WIDTH-1:0] == '0;
                    io.ovf       <= 1'b0;
                    io.dbz       <= isdiv && rb == '0;
                    io.out_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (io.out_ready) begin
                    io.out_valid <= 1'b0;
                    io.in_ready  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
